// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter: byte FIFO, baud divider and 8N1 frame shifter.
// Define WB_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module wb_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

`ifdef WB_UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t      state, state_nx;
  logic [15:0] baud_cnt, cnt_nx;
  logic [2:0]  bit_idx, idx_nx;
  logic [7:0]  shreg;
  logic        tx_bit, pop;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        fifo_empty, fifo_full;

  logic        valid, is_data, stall, ack_d, push, busy;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign valid   = wb_cyc_i & wb_stb_i;
  assign is_data = ~wb_adr_i[2];
  assign stall   = valid & wb_we_i & is_data & wb_sel_i[0] & fifo_full;
  assign ack_d   = valid & ~wb_ack_o & ~stall;
  assign push    = ack_d & wb_we_i & is_data & wb_sel_i[0];

  assign busy   = (state != ST_IDLE);
  assign status = {16'h0, 8'(level), 5'h0, fifo_empty, fifo_full, busy};
  assign irq_o  = fifo_empty & (state == ST_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      wb_ack_o <= ack_d;
      if (ack_d && !wb_we_i && !is_data) wb_dat_o <= status;
      else                               wb_dat_o <= '0;
    end
  end

  // Frame shifter; tx_o is registered from the current state, one cycle behind it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_o     <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= cnt_nx;
      bit_idx  <= idx_nx;
      tx_o     <= tx_bit;
      if (pop) shreg <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = baud_cnt;
    idx_nx   = bit_idx;
    pop      = 1'b0;
    tx_bit   = 1'b1;
    if (state != ST_IDLE) cnt_nx = (baud_cnt == 16'd0) ? DIV_M1 : baud_cnt - 16'd1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cnt_nx   = DIV_M1;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (baud_cnt == 16'd0) begin
          idx_nx   = 3'd0;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_bit = shreg[bit_idx];
        if (baud_cnt == 16'd0) begin
          if (bit_idx == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
            state_nx = ST_PARITY;
`else
            state_nx = ST_STOP;
`endif
          end else begin
            idx_nx = bit_idx + 3'd1;
          end
        end
      end
`ifdef WB_UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_bit = ^shreg;
        if (baud_cnt == 16'd0) state_nx = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_bit = 1'b1;
        if (baud_cnt == 16'd0) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed and randomized writes, serial line decoded by a monitor.
module tb_wb_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef WB_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic        clk, rst;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack, tx, irq;
  logic [31:0] dat_r;

  int n_cmp = 0, n_fail = 0;
  int cycle_no = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  wb_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_dat_o(dat_r),
    .tx_o(tx), .irq_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_no++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef WB_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Returns one cycle after the ack cycle, sampling #1 after the edge.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int max_wait, output int lat, output int ack_at);
    adr = a; dat_w = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ack !== 1'b1 && lat < max_wait);
    ack_at = cycle_no;
    if (ack !== 1'b1) lat = -1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step(1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    adr = a; sel = 4'hf; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ack !== 1'b1 && lat < 50);
    d = dat_r;
    if (ack !== 1'b1) lat = -1;
    cyc = 1'b0; stb = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (irq !== 1'b1 && n < limit) begin step(1); n++; end
    chk("drain_in_time", irq, 1'b1);
    step(4);
  endtask

  // Serial decoder: samples mid-bit and records each byte and its start cycle.
  initial begin : monitor
    logic [7:0] b;
    int t0;
    bit bad;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0 && tx === 1'b0) begin
        t0 = cycle_no; bad = 0;
        repeat (CLK_DIV / 2) begin @(posedge clk); #1; end
        if (tx !== 1'b0) bad = 1;
        for (int j = 0; j < 8; j++) begin
          repeat (CLK_DIV) begin @(posedge clk); #1; end
          b[j] = tx;
        end
`ifdef WB_UART_TX_PARITY_EN
        repeat (CLK_DIV) begin @(posedge clk); #1; end
        if (tx !== ^b) bad = 1;
`endif
        repeat (CLK_DIV) begin @(posedge clk); #1; end
        if (tx !== 1'b1) bad = 1;
        rx_q.push_back(b);
        rx_t.push_back(t0);
        if (bad) frame_err++;
      end
    end
  end

  initial begin : main
    int lat, e1, ack_at, base, err_base, lows;
    logic [31:0] rd;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_irq", irq, 1'b1);
    #22 rst = 1'b0;
    step(1);

    wb_read(32'h4, rd, lat);
    chk("status_after_reset", rd, 32'h4);
    chk("read_lat", lat, 1);
    wb_read(32'h0, rd, lat);
    chk("data_read_zero", rd, 32'h0);

    // Exact waveforms for 0x55 and a random byte.
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom);
      base = rx_q.size();
      wb_write(32'h0, {24'h0, b}, 4'h1, 20, lat, e1);
      chk("write_ack_lat", lat, 1);
      chk("line_idle_E1", tx, 1'b1);
      for (int k = 0; k < FRAME_CYC; k++) begin
        step(1);
        chk($sformatf("frame_%02h_cyc%0d", b, k), tx, exp_bit(b, k / CLK_DIV));
        if (k == 0) chk("irq_low_busy", irq, 1'b0);
      end
      step(1);
      chk("line_idle_after", tx, 1'b1);
      chk("irq_after_frame", irq, 1'b1);
      step(4);
      chk("rx_count_single", rx_q.size() - base, 1);
      if (rx_q.size() > base) chk("rx_byte_single", rx_q[base], b);
    end

    // Back-to-back burst into a depth-4 FIFO; sixth write must stall.
    base = rx_q.size();
    err_base = frame_err;
    for (int i = 0; i < 6; i++) begin
      wb_write(32'h1000_0000, 32'h41 + i, 4'h1, 300, lat, ack_at);
      if (i == 0) e1 = ack_at;
      if (i < 5) chk($sformatf("burst_lat_%0d", i), lat, 1);
      else       chk("stall_ack_cycle", ack_at, e1 + FRAME_CYC + 3);
    end
    wait_idle(8 * FRAME_CYC);
    chk("burst_rx_count", rx_q.size() - base, 6);
    for (int i = 0; i < 6 && base + i < rx_q.size(); i++)
      chk($sformatf("burst_rx_%0d", i), rx_q[base + i], 8'h41 + i);
    if (rx_q.size() - base == 6) begin
      chk("start_latency", rx_t[base], e1 + 2);
      for (int i = 1; i < 6; i++)
        chk($sformatf("frame_spacing_%0d", i), rx_t[base + i] - rx_t[base + i - 1], FRAME_CYC + 1);
    end
    chk("burst_frame_err", frame_err - err_base, 0);

    // STATUS while busy after three pushes.
    base = rx_q.size();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wb_write(32'h0, {24'h0, b}, 4'h1, 20, lat, ack_at);
    end
    wb_read(32'h4, rd, lat);
    chk("status_busy_level2", rd, 32'h0000_0201);
    wait_idle(5 * FRAME_CYC);
    wb_read(32'h4, rd, lat);
    chk("status_drained", rd, 32'h4);
    chk("three_rx_count", rx_q.size() - base, 3);
    for (int i = 0; i < 3 && base + i < rx_q.size(); i++)
      chk($sformatf("three_rx_%0d", i), rx_q[base + i], exp_q[i]);

    // Write without sel[0], and a STATUS write: both acked, neither pushes.
    base = rx_q.size();
    wb_write(32'h0, 32'h41, 4'b0010, 20, lat, ack_at);
    chk("nosel_ack_lat", lat, 1);
    wb_write(32'h4, 32'hff, 4'hf, 20, lat, ack_at);
    chk("status_write_ack_lat", lat, 1);
    lows = 0;
    for (int k = 0; k < 60; k++) begin step(1); if (tx !== 1'b1) lows++; end
    chk("nosel_tx_high", lows, 0);
    wb_read(32'h4, rd, lat);
    chk("nosel_status", rd, 32'h4);
    chk("nosel_no_rx", rx_q.size() - base, 0);

    // Randomized writes with random gaps, checked against the byte queue.
    base = rx_q.size();
    err_base = frame_err;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wb_write(32'h0, {$urandom_range(0, 32'hff_ffff), b}, 4'h1 | 4'($urandom_range(0, 15)),
               400, lat, ack_at);
      if (lat < 0) chk("rand_write_timeout", lat, 1);
      step($urandom_range(0, 60));
    end
    wait_idle(10 * FRAME_CYC);
    chk("rand_rx_count", rx_q.size() - base, 8);
    for (int i = 0; i < 8 && base + i < rx_q.size(); i++)
      chk($sformatf("rand_rx_%0d", i), rx_q[base + i], exp_q[i]);
    chk("rand_frame_err", frame_err - err_base, 0);

    // Asynchronous reset mid-DATA with a stalled write pending.
    for (int i = 0; i < 5; i++) begin
      wb_write(32'h0, 32'h0, 4'h1, 20, lat, ack_at);
      if (i == 0) e1 = ack_at;
    end
    adr = 32'h0; dat_w = 32'h99; sel = 4'h1; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    step(3);
    chk("stalled_ack_low", ack, 1'b0);
    chk("mid_data_tx_low", tx, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_ack", ack, 1'b0);
    chk("async_rst_irq", irq, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step(1);
    chk("rst_hold_tx", tx, 1'b1);
    #3 rst = 1'b0;
    step(1);
    chk("post_rst_irq", irq, 1'b1);
    wb_read(32'h4, rd, lat);
    chk("post_rst_status", rd, 32'h4);
    lows = 0;
    for (int k = 0; k < FRAME_CYC + 10; k++) begin step(1); if (tx !== 1'b1) lows++; end
    chk("post_rst_tx_idle", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
